// File: rtl/if_id_frontend.sv
// Fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Holds the PC, captures fetched words into IF/ID, redirects fetch on taken
// branches and jumps, and stalls on load-use hazards against the ID/EX load.
module if_id_frontend #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // Instruction memory (combinational read)
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    // Redirect from the decode control unit
    input  logic [1:0]       pc_src,
    // Load in ID/EX, for hazard detection
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    // IF/ID fields towards decode
    output logic [5:0]       opcode,
    output logic [5:0]       func,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm,
    output logic [31:0]      pc4,
    output logic             nop_out,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [1:0] PcSrcBranch = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // Architectural state
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Derived values
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        rs_hit;
    logic        rt_hit;

    // IF/ID fields are straight slices of the pipeline register
    assign imem_addr  = pc_q;
    assign opcode     = instr_q[31:26];
    assign rs         = instr_q[25:21];
    assign rt         = instr_q[20:16];
    assign rd         = instr_q[15:11];
    assign imm        = instr_q[15:0];
    assign func       = instr_q[5:0];
    assign pc4        = pc4_q;
    assign bubble_cnt = cnt_q;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jump_target   = {pc4_q[31:28], instr_q[25:0], 2'b00};

    // rt is compared for every opcode; a false hit only costs one cycle
    assign rs_hit  = (ex_rt == instr_q[25:21]);
    assign rt_hit  = (ex_rt == instr_q[20:16]);
    assign stall   = valid_q & ex_mem_read & (ex_rt != 5'd0) & (rs_hit | rt_hit);
    assign nop_out = ~valid_q | stall;

    // Next PC and IF/ID contents; a stall freezes both and outranks any redirect
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (!stall) begin
            if (pc_src == PcSrcBranch) begin
                pc_d    = branch_target;
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end else if (pc_src == PcSrcJump) begin
                pc_d    = jump_target;
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end else if (!imem_ready) begin
                // Hold the PC and retry; the bubble keeps all fields at zero
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end else begin
                pc_d    = pc_plus4;
                instr_d = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    // Saturating count of cycles in which decode sees a squashed slot
    always_comb begin
        cnt_d = cnt_q;
        if (nop_out && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_RESET;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/if_id_frontend.md
Name: if_id_frontend

Overview:
- Fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Sits directly upstream of the decode control unit and drives its opcode, func and nopIn inputs.
- Consumes the control unit's 2-bit PC-select back to redirect fetch on taken branches and jumps.
- Detects load-use hazards and either stalls or inserts bubbles.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  instruction-memory address; equals the PC register.
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- imem_ready  in  1  imem_rdata is valid this cycle.
- pc_src  in  2  from control unit: 0 = sequential, 1 = branch taken, 2 = jump, 3 = treated as 0.
- ex_mem_read  in  1  the instruction in ID/EX is a load.
- ex_rt  in  5  destination register of that load.
- opcode  out  6  IF/ID instr[31:26].
- func  out  6  IF/ID instr[5:0].
- rs  out  5  IF/ID instr[25:21].
- rt  out  5  IF/ID instr[20:16].
- rd  out  5  IF/ID instr[15:11].
- imm  out  16  IF/ID instr[15:0].
- pc4  out  32  IF/ID PC+4.
- nop_out  out  1  to control unit nopIn; the ID instruction must be squashed.
- stall  out  1  load-use stall active this cycle.
- bubble_cnt  out  CNT_W  count of cycles with nop_out=1, saturating.

Behaviour:
- Reset (async, rst_n=0): PC=PC_RESET, IF/ID instr=0, pc4=0, valid=0, bubble_cnt=0. All derived outputs follow, so nop_out=1 and stall=0.
- Outputs opcode, func, rs, rt, rd, imm and pc4 are direct fields of the IF/ID register (zero latency from the register).
- stall (combinational):
  - stall = valid & ex_mem_read & (ex_rt != 0) & (ex_rt == rs | ex_rt == rt).
  - rt is compared conservatively for all opcodes.
- nop_out = ~valid | stall (combinational).
- Targets (combinational, from the IF/ID contents):
  - branch target = pc4 + {{14{imm[15]}}, imm, 2'b00}, mod 2^32.
  - jump target = {pc4[31:28], instr[25:0], 2'b00}.
- Per-edge update, first matching rule wins:
  1. stall=1: PC holds, IF/ID holds. pc_src is ignored, because the control unit sees nopIn=1 and outputs 0 anyway.
  2. pc_src==1: PC <= branch target. IF/ID <= bubble (valid=0, instr=0). imem_ready is ignored.
  3. pc_src==2: PC <= jump target. IF/ID <= bubble.
  4. imem_ready=0: PC holds. IF/ID <= bubble.
  5. Otherwise: PC <= PC+4 (wraps mod 2^32). IF/ID <= {instr=imem_rdata, pc4=PC+4, valid=1}.
- A branch or jump costs exactly one bubble cycle; a load-use hazard costs exactly one stall cycle. stall clears once the load leaves ID/EX.
- Simultaneous stall and imem_ready=0: the stall rule wins and IF/ID holds its instruction, so it is not lost.
- bubble_cnt: increments on every edge where nop_out=1 and rst_n=1. It holds at 2^CNT_W-1 (no wrap).
- Reset asserted mid-stall or mid-redirect: all state returns to the reset values immediately; the first fetch after release is from PC_RESET.
- No X propagation: when valid=0 every IF/ID field is 0.

Test Plan:
1. Reset then sequential fetch: release rst_n with imem_ready=1 and imem returning 32'h0000_0000 (the word at PC_RESET) then an ADD word 32'h0109_5020 at 0x4. Require imem_addr sequence 0x0, 0x4, 0x8. Require, at the edge after imem_addr=0x4 with no stall/redirect (ADD in IF/ID): opcode=0, func=6'b100000, rs=8, rt=9, rd=10, pc4=0x8, nop_out=0. Require nop_out=1 for the first cycle after reset.
2. Load-use: IF/ID holds rs=5, with ex_mem_read=1 and ex_rt=5. Require stall=1, nop_out=1, and PC and IF/ID unchanged for one edge. With ex_rt=0 instead, require stall=0.
3. Branch taken: IF/ID holds a BEQ at pc4=0x20 with imm=16'hFFFC and pc_src=1. Require next PC=0x10, one bubble (nop_out=1), then fetch from 0x10.
4. Jump: pc4=0x4000_0010, instr[25:0]=26'h10, pc_src=2. Require next PC=0x4000_0040 and one bubble.
5. imem_ready low for 3 cycles: require PC held, 3 bubbles, and bubble_cnt increased by 3. Stall plus imem_ready=0 together: require IF/ID retained.
6. Async reset mid-stall: assert rst_n=0 between edges. Require PC=PC_RESET, bubble_cnt=0 and nop_out=1 immediately, without waiting for a clock edge.
